// File: rtl/uart_mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register
// offsets, load/store encodings, serializer states and register bit indices.
package uart_mmio_pkg;

  // Register offsets, selected by addr[3:2]
  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_DIV    = 2'd2;
  localparam logic [1:0] OFF_CTRL   = 2'd3;

  // CPU data-port access types (funct3 encoding)
  localparam logic [2:0] MEMOP_SB  = 3'b000;
  localparam logic [2:0] MEMOP_SH  = 3'b001;
  localparam logic [2:0] MEMOP_SW  = 3'b010;
  localparam logic [2:0] MEMOP_LBU = 3'b100;
  localparam logic [2:0] MEMOP_LHU = 3'b101;

  // Serializer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  // STATUS bit positions
  localparam int STAT_EMPTY   = 32'd0;
  localparam int STAT_FULL    = 32'd1;
  localparam int STAT_BUSY    = 32'd2;
  localparam int STAT_OVF     = 32'd3;
  localparam int STAT_CNT_LSB = 32'd8;

  // CTRL bit positions
  localparam int CTRL_EN      = 32'd0;
  localparam int CTRL_IE      = 32'd1;
  localparam int CTRL_OVF_CLR = 32'd2;

  // A divisor below 2 cannot produce a sensible bit period; clamp it to 2
  function automatic logic [15:0] div_sanitize(input logic [15:0] d);
    logic [15:0] r;
    if (d < 16'd2) begin
      r = 16'd2;
    end else begin
      r = d;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers. Read data is presented
// combinationally from the head entry; a push on a full FIFO is accepted
// only when a pop frees the slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic             full_s;
  logic             empty_s;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty_s   = (wr_ptr_r == rd_ptr_r);
  assign full_s    = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign do_pop_s  = pop & ~empty_s;
  assign do_push_s = push & (~full_s | do_pop_s);

  assign rdata = mem_r[rd_ptr_r[AW-1:0]];
  assign full  = full_s;
  assign empty = empty_s;
  assign count = wr_ptr_r - rd_ptr_r;

  // Storage array: write the tail entry on an accepted push
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (do_push_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wdata;
    end
  end

  // Pointer update for accepted pushes and pops
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter. Sits beside data memory on the CPU
// data port, buffers stored bytes in a FIFO and serializes them onto txd.
module mmio_uart_tx
  import uart_mmio_pkg::*;
#(
  parameter int                   addrWidth  = 32,
  parameter int                   dataWidth  = 32,
  parameter logic [addrWidth-1:0] BASE       = 32'h1000_0000,
  parameter int                   FIFO_DEPTH = 16,
  parameter logic [15:0]          DIV_RESET  = 16'd868
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [addrWidth-1:0] addr,
  input  logic [dataWidth-1:0] din,
  input  logic [2:0]           memOp,
  input  logic                 we,
  input  logic                 re,
  output logic                 hit,
  output logic [dataWidth-1:0] dout,
  output logic                 txd,
  output logic                 irq
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic                 hit_s;
  logic [1:0]           off_s;
  logic                 wr_s;
  logic                 rd_s;
  logic                 push_req_s;
  logic                 start_frame_s;
  logic                 ovf_set_s;
  logic                 ovf_clr_s;
  logic [7:0]           fifo_rdata_s;
  logic                 fifo_full_s;
  logic                 fifo_empty_s;
  logic [CNT_W-1:0]     fifo_count_s;
  logic [dataWidth-1:0] status_s;
  logic [dataWidth-1:0] rdata_s;
  logic                 unused_s;

  logic [15:0]          div_r;
  logic                 en_r;
  logic                 ie_r;
  logic                 overflow_r;
  logic [dataWidth-1:0] dout_r;
  logic                 irq_r;

  tx_state_e            state_r;
  logic [7:0]           shift_r;
  logic [2:0]           bit_cnt_r;
  logic [15:0]          baud_cnt_r;
  logic [15:0]          frame_div_r;
  logic                 txd_r;

  // All store widths write the low bits, so the access type is not decoded
  assign unused_s = ^{memOp, din[dataWidth-1:16], addr[1:0]};

  assign hit_s      = (addr[addrWidth-1:4] == BASE[addrWidth-1:4]);
  assign off_s      = addr[3:2];
  assign wr_s       = we & hit_s;
  assign rd_s       = re & hit_s;
  assign push_req_s = wr_s & (off_s == OFF_TXDATA);
  assign ovf_clr_s  = wr_s & (off_s == OFF_CTRL) & din[CTRL_OVF_CLR];
  // A push onto a full FIFO is lost unless the serializer pops this cycle
  assign ovf_set_s  = push_req_s & fifo_full_s & ~start_frame_s;

  assign hit  = hit_s;
  assign dout = dout_r;
  assign txd  = txd_r;
  assign irq  = irq_r;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push_req_s),
    .pop   (start_frame_s),
    .wdata (din[7:0]),
    .rdata (fifo_rdata_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  // Frame launch: from IDLE, or straight out of the last STOP clock so
  // back-to-back frames carry no extra idle time
  always_comb begin
    start_frame_s = 1'b0;
    if (en_r && !fifo_empty_s) begin
      case (state_r)
        ST_IDLE: start_frame_s = 1'b1;
        ST_STOP: start_frame_s = (baud_cnt_r == 16'd0);
        default: start_frame_s = 1'b0;
      endcase
    end else begin
      start_frame_s = 1'b0;
    end
  end

  // STATUS word assembly
  always_comb begin
    status_s                            = '0;
    status_s[STAT_EMPTY]                = fifo_empty_s;
    status_s[STAT_FULL]                 = fifo_full_s;
    status_s[STAT_BUSY]                 = (state_r != ST_IDLE);
    status_s[STAT_OVF]                  = overflow_r;
    status_s[STAT_CNT_LSB +: CNT_W]     = fifo_count_s;
  end

  // Read mux over the register map
  always_comb begin
    rdata_s = '0;
    case (off_s)
      OFF_TXDATA: rdata_s = '0;
      OFF_STATUS: rdata_s = status_s;
      OFF_DIV:    rdata_s = {{(dataWidth-16){1'b0}}, div_r};
      OFF_CTRL:   rdata_s = {{(dataWidth-2){1'b0}}, ie_r, en_r};
      default:    rdata_s = '0;
    endcase
  end

  // Control registers, sticky overflow, registered read data and interrupt
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      div_r      <= DIV_RESET;
      en_r       <= 1'b0;
      ie_r       <= 1'b0;
      overflow_r <= 1'b0;
      dout_r     <= '0;
      irq_r      <= 1'b0;
    end else begin
      if (wr_s) begin
        case (off_s)
          OFF_DIV: begin
            div_r <= div_sanitize(din[15:0]);
          end
          OFF_CTRL: begin
            en_r <= din[CTRL_EN];
            ie_r <= din[CTRL_IE];
          end
          default: begin
          end
        endcase
      end
      if (ovf_clr_s) begin
        overflow_r <= 1'b0;
      end else if (ovf_set_s) begin
        overflow_r <= 1'b1;
      end
      if (rd_s) begin
        dout_r <= rdata_s;
      end
      irq_r <= ie_r & fifo_empty_s & (state_r == ST_IDLE);
    end
  end

  // Serializer: start bit, 8 data bits LSB first, stop bit, each frame_div clocks
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      shift_r     <= 8'd0;
      bit_cnt_r   <= 3'd0;
      baud_cnt_r  <= 16'd0;
      frame_div_r <= 16'd2;
      txd_r       <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_frame_s) begin
            shift_r     <= fifo_rdata_s;
            bit_cnt_r   <= 3'd0;
            baud_cnt_r  <= div_r - 16'd1;
            frame_div_r <= div_r;
            txd_r       <= 1'b0;
            state_r     <= ST_START;
          end else begin
            txd_r <= 1'b1;
          end
        end
        ST_START: begin
          if (baud_cnt_r == 16'd0) begin
            baud_cnt_r <= frame_div_r - 16'd1;
            txd_r      <= shift_r[0];
            state_r    <= ST_DATA;
          end else begin
            baud_cnt_r <= baud_cnt_r - 16'd1;
          end
        end
        ST_DATA: begin
          if (baud_cnt_r == 16'd0) begin
            baud_cnt_r <= frame_div_r - 16'd1;
            if (bit_cnt_r == 3'd7) begin
              txd_r   <= 1'b1;
              state_r <= ST_STOP;
            end else begin
              bit_cnt_r <= bit_cnt_r + 3'd1;
              shift_r   <= {1'b0, shift_r[7:1]};
              txd_r     <= shift_r[1];
            end
          end else begin
            baud_cnt_r <= baud_cnt_r - 16'd1;
          end
        end
        ST_STOP: begin
          if (baud_cnt_r == 16'd0) begin
            if (start_frame_s) begin
              shift_r     <= fifo_rdata_s;
              bit_cnt_r   <= 3'd0;
              baud_cnt_r  <= div_r - 16'd1;
              frame_div_r <= div_r;
              txd_r       <= 1'b0;
              state_r     <= ST_START;
            end else begin
              txd_r   <= 1'b1;
              state_r <= ST_IDLE;
            end
          end else begin
            baud_cnt_r <= baud_cnt_r - 16'd1;
          end
        end
        default: begin
          txd_r   <= 1'b1;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed self-checking bench for mmio_uart_tx.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam logic [3:0]  A_TX = 4'h0;
  localparam logic [3:0]  A_ST = 4'h4;
  localparam logic [3:0]  A_DV = 4'h8;
  localparam logic [3:0]  A_CT = 4'hC;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] din;
  logic [2:0]  memOp;
  logic        we;
  logic        re;
  logic        hit;
  logic [31:0] dout;
  logic        txd;
  logic        irq;

  int n_vec = 0;
  int n_err = 0;

  logic        txd_q  [90];
  logic        aux_q  [90];
  logic [31:0] rd;
  logic [63:0] obs;
  int          first;
  int          busy_cnt;
  int          irq_hi;

  mmio_uart_tx dut (
    .clock (clock),
    .reset (reset),
    .addr  (addr),
    .din   (din),
    .memOp (memOp),
    .we    (we),
    .re    (re),
    .hit   (hit),
    .dout  (dout),
    .txd   (txd),
    .irq   (irq)
  );

  always #5 clock = ~clock;

  task automatic chk_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called and returns at a falling edge; the store lands on the rising edge between
  task automatic bus_write(input logic [3:0] off, input logic [31:0] data, input logic [2:0] op);
    addr  = BASE + {28'd0, off};
    din   = data;
    memOp = op;
    we    = 1'b1;
    @(negedge clock);
    we    = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] off, output logic [31:0] data);
    addr  = BASE + {28'd0, off};
    memOp = 3'b010;
    re    = 1'b1;
    @(negedge clock);
    re    = 1'b0;
    data  = dout;
  endtask

  // Expected txd sequence of one 8N1 frame, one sample per clock, bit 0 first
  function automatic logic [63:0] frame_vec(input logic [7:0] b, input int div);
    logic [63:0] v;
    int k;
    v = '0;
    for (int j = 0; j < 10 * div; j++) begin
      k = j / div;
      if (k == 0) v[j] = 1'b0;
      else if (k <= 8) v[j] = b[k-1];
      else v[j] = 1'b1;
    end
    return v;
  endfunction

  function automatic int find_low(input int lim);
    int f;
    f = -1;
    for (int i = 0; i < lim; i++) begin
      if (f < 0 && txd_q[i] == 1'b0) f = i;
    end
    return f;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; addr = '0; din = '0; memOp = 3'b000; we = 1'b0; re = 1'b0;
    #12;
    chk_vec("rst_txd",  {63'd0, txd}, 64'd1);
    chk_vec("rst_dout", {32'd0, dout}, 64'd0);
    chk_vec("rst_irq",  {63'd0, irq}, 64'd0);
    @(negedge clock); reset = 1'b1;
    @(negedge clock);
    bus_read(A_ST, rd); chk_vec("rst_status", {32'd0, rd}, 64'h1);
    bus_read(A_DV, rd); chk_vec("rst_div",    {32'd0, rd}, 64'h364);

    // Single frame 0xA5 at DIV=4, txd and busy observed every clock
    bus_write(A_DV, 32'd4, 3'b010);
    bus_write(A_CT, 32'd1, 3'b010);
    bus_write(A_TX, 32'hA5, 3'b000);
    addr = BASE + {28'd0, A_ST}; re = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      txd_q[i] = txd;
      aux_q[i] = dout[2];
    end
    re = 1'b0;
    first = find_low(60);
    chk_vec("sf_start_seen", {63'd0, (first >= 0)}, 64'd1);
    if (first < 0) first = 0;
    if (first > 19) first = 19;
    obs = '0;
    for (int j = 0; j < 40; j++) obs[j] = txd_q[first + j];
    chk_vec("sf_frame", obs, frame_vec(8'hA5, 4));
    chk_vec("sf_idle_after", {63'd0, txd_q[first + 40]}, 64'd1);
    busy_cnt = 0;
    for (int i = 0; i < 60; i++) busy_cnt += int'(aux_q[i]);
    chk_vec("sf_busy_clocks", 64'(busy_cnt), 64'd40);

    // Three back-to-back frames at DIV=2, irq enabled
    bus_write(A_DV, 32'd2, 3'b010);
    bus_write(A_CT, 32'd3, 3'b010);
    fork
      begin
        bus_write(A_TX, 32'h01, 3'b000);
        bus_write(A_TX, 32'h02, 3'b000);
        bus_write(A_TX, 32'h03, 3'b000);
      end
      begin
        for (int i = 0; i < 90; i++) begin
          @(negedge clock);
          txd_q[i] = txd;
          aux_q[i] = irq;
        end
      end
    join
    first = find_low(90);
    chk_vec("fo_start_seen", {63'd0, (first >= 0)}, 64'd1);
    if (first < 0) first = 0;
    if (first > 20) first = 20;
    obs = '0;
    for (int j = 0; j < 60; j++) obs[j] = txd_q[first + j];
    chk_vec("fo_frames", obs,
            frame_vec(8'h01, 2) | (frame_vec(8'h02, 2) << 20) | (frame_vec(8'h03, 2) << 40));
    irq_hi = 0;
    for (int j = 0; j < 61; j++) irq_hi += int'(aux_q[first + j]);
    chk_vec("fo_irq_low_in_frames", 64'(irq_hi), 64'd0);
    chk_vec("fo_irq_rise", {63'd0, aux_q[first + 61]}, 64'd1);

    // Overflow with serializer disabled
    bus_write(A_CT, 32'd0, 3'b010);
    for (int i = 0; i < 17; i++) bus_write(A_TX, 32'(i), 3'b000);
    bus_read(A_ST, rd); chk_vec("ovf_status", {32'd0, rd}, 64'h100A);
    bus_write(A_CT, 32'd4, 3'b010);
    bus_read(A_ST, rd); chk_vec("ovf_cleared", {32'd0, rd}, 64'h1002);
    bus_read(A_CT, rd); chk_vec("ctrl_readback", {32'd0, rd}, 64'h0);

    // Push on the very cycle the serializer pops a full FIFO
    bus_write(A_CT, 32'd1, 3'b010);
    bus_write(A_TX, 32'h55, 3'b000);
    bus_read(A_ST, rd); chk_vec("pushpop_status", {32'd0, rd}, 64'h1006);
    rd = '0;
    for (int i = 0; i < 600 && rd != 32'h1; i++) bus_read(A_ST, rd);
    chk_vec("drain_done", {32'd0, rd}, 64'h1);
    bus_write(A_CT, 32'd0, 3'b010);

    // Read latency and address decode
    bus_read(A_DV, rd); chk_vec("rd_div", {32'd0, rd}, 64'd2);
    addr = BASE + 32'h10; #1;
    chk_vec("hit_outside", {63'd0, hit}, 64'd0);
    re = 1'b1; @(negedge clock); re = 1'b0;
    chk_vec("dout_held", {32'd0, dout}, 64'd2);
    addr = BASE + 32'hC; #1;
    chk_vec("hit_inside", {63'd0, hit}, 64'd1);
    @(negedge clock);
    bus_read(4'hA, rd); chk_vec("rd_low_bits_ignored", {32'd0, rd}, 64'd2);
    bus_read(A_TX, rd); chk_vec("rd_txdata_zero", {32'd0, rd}, 64'd0);

    // Divisor clamping and width
    bus_write(A_DV, 32'd9, 3'b001);
    bus_write(A_DV, 32'd1, 3'b001);
    bus_read(A_DV, rd); chk_vec("div_clamp1", {32'd0, rd}, 64'd2);
    bus_write(A_DV, 32'd9, 3'b001);
    bus_write(A_DV, 32'd0, 3'b000);
    bus_read(A_DV, rd); chk_vec("div_clamp0", {32'd0, rd}, 64'd2);
    bus_write(A_DV, 32'h0001_0005, 3'b010);
    bus_read(A_DV, rd); chk_vec("div_low16", {32'd0, rd}, 64'd5);

    // Simultaneous write and read: dout captures the old value
    addr = BASE + {28'd0, A_DV}; din = 32'd7; we = 1'b1; re = 1'b1;
    @(negedge clock); we = 1'b0; re = 1'b0;
    chk_vec("we_re_old", {32'd0, dout}, 64'd5);
    bus_read(A_DV, rd); chk_vec("we_re_new", {32'd0, rd}, 64'd7);

    // Reset in the middle of a frame
    bus_write(A_DV, 32'd4, 3'b010);
    bus_write(A_CT, 32'd3, 3'b010);
    bus_write(A_TX, 32'h00, 3'b000);
    repeat (3) @(negedge clock);
    chk_vec("midframe_low", {63'd0, txd}, 64'd0);
    reset = 1'b0; #1;
    chk_vec("midreset_txd", {63'd0, txd}, 64'd1);
    chk_vec("midreset_dout", {32'd0, dout}, 64'd0);
    @(negedge clock); reset = 1'b1;
    @(negedge clock);
    bus_read(A_ST, rd); chk_vec("post_rst_status", {32'd0, rd}, 64'h1);
    bus_read(A_DV, rd); chk_vec("post_rst_div",    {32'd0, rd}, 64'h364);
    bus_read(A_CT, rd); chk_vec("post_rst_ctrl",   {32'd0, rd}, 64'h0);
    chk_vec("post_rst_txd", {63'd0, txd}, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
